// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: FSM encoding, load funct3 codes
// and the width of the byte offset inside a word.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int OFS_W = 2;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: extracts and extends the addressed byte/half/word
// from a read word, and flags misaligned or unsupported load types.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]       funct3,
  input  logic [OFS_W-1:0] offset,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data,
  output logic             misalign,
  output logic             illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3_LHU: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (offset != '0);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: sole writer of the integer register file, handles ALU results and
// word-read loads. Define WB_FWD_EN to expose the fwd_* bypass outputs for decode.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_NUM_BIT = 5,
  parameter int TIMEOUT     = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [REG_NUM_BIT-1:0] in_rd,
  input  logic                   in_rd_wen,
  input  logic                   in_is_load,
  input  logic [2:0]             in_funct3,
  input  logic [XLEN-1:0]        in_result,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [XLEN-1:0]        mem_req_addr,
  input  logic                   mem_rvalid,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic [REG_NUM_BIT-1:0] rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   rf_wen,
  output logic                   retire_valid,
  output logic [XLEN-1:0]        retire_pc,
  output logic                   wb_err
`ifdef WB_FWD_EN
  ,
  output logic                   fwd_valid,
  output logic [REG_NUM_BIT-1:0] fwd_rd,
  output logic [XLEN-1:0]        fwd_data
`endif
);

  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT);

  wb_state_e              state;
  logic [TIMEOUT_W-1:0]   cnt;
  logic [TIMEOUT_W-1:0]   cnt_inc;

  logic [REG_NUM_BIT-1:0] rd_p1;
  logic                   rd_wen_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [2:0]             f3_p1;
  logic [OFS_W-1:0]       ofs_p1;

  logic [2:0]             al_f3;
  logic [OFS_W-1:0]       al_ofs;
  logic [XLEN-1:0]        al_data;
  logic                   al_misalign;
  logic                   al_illegal;
  logic                   accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

  // The aligner checks the incoming load while idle and formats the response otherwise.
  assign al_f3  = (state == IDLE) ? in_funct3 : f3_p1;
  assign al_ofs = (state == IDLE) ? in_result[OFS_W-1:0] : ofs_p1;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3   (al_f3),
    .offset   (al_ofs),
    .rdata    (mem_rdata),
    .data     (al_data),
    .misalign (al_misalign),
    .illegal  (al_illegal)
  );

  // p0 -> p1: capture the load context while its memory access is in flight.
  always_ff @(posedge clk) begin
    if (accept && in_is_load) begin
      rd_p1     <= in_rd;
      rd_wen_p1 <= in_rd_wen;
      pc_p1     <= in_pc;
      f3_p1     <= in_funct3;
      ofs_p1    <= in_result[OFS_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rf_wen        <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      retire_valid  <= 1'b0;
      retire_pc     <= '0;
      wb_err        <= 1'b0;
    end else begin
      rf_wen       <= 1'b0;
      retire_valid <= 1'b0;
      wb_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!in_is_load) begin
              rf_wen       <= in_rd_wen && (in_rd != '0);
              rf_waddr     <= in_rd;
              rf_wdata     <= in_result;
              retire_valid <= 1'b1;
              retire_pc    <= in_pc;
            end else if (al_misalign || al_illegal) begin
              wb_err       <= 1'b1;
              retire_valid <= 1'b1;
              retire_pc    <= in_pc;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_result[XLEN-1:OFS_W], {OFS_W{1'b0}}};
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            cnt           <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state        <= IDLE;
            rf_wen       <= rd_wen_p1 && (rd_p1 != '0);
            rf_waddr     <= rd_p1;
            rf_wdata     <= al_data;
            retire_valid <= 1'b1;
            retire_pc    <= pc_p1;
          end else if (cnt_inc == TO_LIMIT) begin
            // Counter keeps its saturated value; it is cleared on the next request.
            state        <= IDLE;
            cnt          <= cnt_inc;
            wb_err       <= 1'b1;
            retire_valid <= 1'b1;
            retire_pc    <= pc_p1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = rf_wen;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly upstream of the integer register file: the sole driver of the register file's write port (waddr/wdata/wen).
- Accepts completed instructions from the execute stage over a valid/ready handshake.
- ALU results are written after one cycle. Loads issue a word read to data memory, wait for the response, then align and sign/zero-extend before writing.
- Also produces a one-cycle retire pulse with PC for the difftest harness.

Parameters:
- XLEN, 32, data/address width
- REG_NUM_BIT, 5, register index width
- TIMEOUT, 255, max cycles in WAIT before a load is aborted
- TIMEOUT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_rd  in  REG_NUM_BIT  destination register
- in_rd_wen  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- in_funct3  in  3  load type (valid only when in_is_load)
- in_result  in  XLEN  ALU result, or effective address for loads
- mem_req_valid  out  1  load read request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- rf_waddr  out  REG_NUM_BIT  register file write index
- rf_wdata  out  XLEN  register file write data
- rf_wen  out  1  register file write enable, one-cycle pulse
- retire_valid  out  1  one-cycle retire pulse
- retire_pc  out  XLEN  PC of retiring instruction
- wb_err  out  1  one-cycle pulse: misaligned/illegal load or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rf_wen, retire_valid, wb_err, mem_req_valid=0; rf_waddr, rf_wdata, retire_pc, mem_req_addr, timeout counter=0. Any outstanding load is dropped.
- States:
  - IDLE: in_ready=1.
  - REQ: in_ready=0; mem_req_valid=1, held stable with mem_req_addr until mem_req_ready.
  - WAIT: in_ready=0; waits for mem_rvalid.
- Non-load accept (in_valid&in_ready&!in_is_load): next cycle rf_wen=in_rd_wen&(in_rd!=0), rf_waddr=in_rd, rf_wdata=in_result, retire_valid=1, retire_pc=in_pc. State stays IDLE, so back-to-back ALU results sustain 1 per cycle.
- Load accept: latch rd, rd_wen, pc, funct3, addr[1:0]; go to REQ.
  - Pre-check on accept, misalignment: lh/lhu with addr[0]=1; lw with addr[1:0]!=0.
  - Pre-check on accept, illegal funct3: 011, 110, 111.
  - If either check fails: no memory request, rf_wen=0; next cycle wb_err=1 and retire_valid=1; state stays IDLE.
- REQ -> WAIT on mem_req_ready; timeout counter cleared.
- WAIT -> IDLE on mem_rvalid. Next cycle rf_wen=rd_wen&(rd!=0), rf_wdata=aligned data, retire_valid=1.
  - mem_rvalid outside WAIT is ignored.
  - The response must arrive at least one cycle after request acceptance.
- Alignment (offset = addr[1:0]):
  - lb/lbu (000/100): byte = rdata[8*offset+:8], sign/zero-extended.
  - lh/lhu (001/101): half = rdata[16*addr[1]+:16], sign/zero-extended.
  - lw (010): whole word.
- Timeout: counter increments each WAIT cycle. On reaching TIMEOUT without mem_rvalid: return to IDLE; next cycle wb_err=1, retire_valid=1, rf_wen=0. Counter saturates and never wraps.
- rd=0: rf_wen never asserted; retire still pulses.
- All rf_*, retire_*, wb_err outputs are registered. Pulses last exactly one cycle unless a new write-back occurs the following cycle.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid(1), fwd_rd(REG_NUM_BIT), fwd_data(XLEN), combinationally equal to rf_wen/rf_waddr/rf_wdata. Decode bypasses the register file's one-cycle write latency from these.
- Undefined: ports absent; decode reads the register file only.

Decomposition:
- Package wb_pkg:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2)
  - funct3 constants F3_LB/LH/LW/LBU/LHU
  - helper constant for word-offset width (2)
- Sub-module load_align: combinational; inputs funct3, offset, rdata; outputs data and misalign/illegal flags. Reused by the pre-check and the WAIT-exit path.

Test Plan:
- Reset during WAIT (rst_n low 1 cycle) -> state IDLE, in_ready=1, no rf_wen/retire. A late mem_rvalid is ignored.
- Back-to-back ALU: rd=5 result 0x1234 then rd=6 result 0xABCD on consecutive cycles -> rf_wen high 2 consecutive cycles with (5,0x1234), (6,0xABCD); in_ready stays 1.
- lb addr 0x8000_0003, mem_rdata 0x80FF_FF00, rd=10 -> mem_req_addr 0x8000_0000; rf_wdata 0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
- lh addr 0x8000_0002, mem_rdata 0x8001_7FFF, rd=7 -> rf_wdata 0xFFFF_8001. lh addr 0x8000_0001 -> no mem_req_valid; wb_err and retire_valid pulse; rf_wen=0.
- lw with mem_req_ready held low 3 cycles -> mem_req_valid/addr stable throughout; single write after mem_rvalid.
- lw, rd=0, mem_rdata 0xDEAD_BEEF -> retire pulse, rf_wen=0. Separate load with no response for TIMEOUT cycles -> wb_err pulse, return to IDLE.
